// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
// Op encodings, FSM state type and default operand width.
package serial_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit combinational ALU slice used by the serial sequencer.
// Carry only propagates for ADD; logic ops force carry_out low.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [1:0] op,
    output logic       y,
    output logic       carry_out
);

    // Per-bit function select
    always_comb begin
        y         = 1'b0;
        carry_out = 1'b0;
        case (op)
            OP_NAND: y = ~(a & b);
            OP_ADD: begin
                y         = a ^ b ^ carry_in;
                carry_out = (a & b) | ((a ^ b) & carry_in);
            end
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one operand bit per cycle, LSB first.
// Optional SERIAL_ALU_SEQ_SUB_EN adds a sub port turning ADD into A-B.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ALU_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [1:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic accept;
    logic last_bit;
    logic inv_b;
    logic seed;
    logic b_bit;
    logic y;
    logic c_nx;

    assign accept   = (state == IDLE) && start;
    assign last_bit = (cnt == LAST);
    assign busy     = (state == SHIFT);

`ifdef SERIAL_ALU_SEQ_SUB_EN
    logic sub_q;

    // Subtract = add with inverted B and carry seeded high
    assign inv_b = sub_q && (op_q == OP_ADD);
    assign seed  = sub && (op == OP_ADD);
`else
    assign inv_b = 1'b0;
    assign seed  = 1'b0;
`endif

    assign b_bit = b_sr[0] ^ inv_b;

    serial_alu_slice u_slice (
        .a         (a_sr[0]),
        .b         (b_bit),
        .carry_in  (carry),
        .op        (op_q),
        .y         (y),
        .carry_out (c_nx)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state: DONE lasts one cycle, SHIFT lasts WIDTH cycles
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef SERIAL_ALU_SEQ_SUB_EN
    // Subtract mode is latched together with the opcode
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub;
        end
    end
`endif

    // Operand capture and serial datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            op_q  <= OP_NAND;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            r_sr  <= '0;
            op_q  <= op;
            carry <= seed;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            r_sr  <= {y, r_sr[WIDTH-1:1]};
            carry <= c_nx;
            cnt   <= cnt + 1'b1;
        end
    end

    // Publish result flags and the done pulse on leaving DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                result <= r_sr;
                cout   <= carry;
                zero   <= (r_sr == '0);
            end
        end
    end

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 NAND, 01 ADD, 10 XOR, 11 XNOR.
REQ-006 a_in  input  WIDTH  operand A, captured on accepted start.
REQ-007 b_in  input  WIDTH  operand B, captured on accepted start.
REQ-008 busy  output  1  high while in SHIFT.
REQ-009 done  output  1  one-cycle pulse when result becomes valid.
REQ-010 result  output  WIDTH  registered result, held stable until the next accepted start.
REQ-011 cout  output  1  final carry of ADD; 0 for logic ops.
REQ-012 zero  output  1  high when result == 0; updated with done.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
- IDLE->SHIFT on start=1.
- SHIFT->DONE after exactly WIDTH cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-014 On the accepted start edge: latch a_in, b_in and op; clear the carry flop to 0; clear the bit counter.
REQ-015 Each SHIFT cycle processes one bit, LSB first, through the slice:
- ADD: sum = a^b^carry; next carry = a&b | (a^b)&carry.
- Logic ops: per-bit result only; carry held at 0.
REQ-016 Result bits shift in MSB-side and shift right each cycle, so bit 0 is aligned after WIDTH cycles.
REQ-017 Latency: start sampled at edge k -> done=1, result, cout and zero valid after edge k+WIDTH+1.
REQ-018 start while busy or in DONE is ignored: no restart, no queuing, and latched operands are not disturbed.
REQ-019 op, a_in and b_in changes after acceptance have no effect on the operation in progress.
REQ-020 Bit counter is ceil(log2(WIDTH))+1 bits wide; it never wraps during an operation.
REQ-021 Back-to-back operation: start high in the cycle after done is accepted; minimum issue interval is WIDTH+2 cycles.

Reset
REQ-022 rst=1 at any edge, including mid-SHIFT, forces all of the following:
- FSM to IDLE.
- busy=0, done=0, result=0, cout=0, zero=0 (zero=0 until first done).
- carry, counter and operand shift registers to 0.
REQ-023 rst takes priority over start in the same cycle.

Configuration
REQ-024 Macro SERIAL_ALU_SEQ_SUB_EN.
- Defined: adds input port sub (1 bit), latched with op. When op=01 and sub=1, B is inverted bitwise and carry seeds to 1, giving A-B. cout=1 means no borrow.
- Undefined: port sub is absent; op=01 is always ADD.

Structure
REQ-025 Shared package serial_alu_pkg holds:
- op encoding constants (OP_NAND, OP_ADD, OP_XOR, OP_XNOR);
- FSM state typedef;
- default WIDTH constant.
REQ-026 One sub-module serial_alu_slice (combinational 1-bit slice): inputs a, b, carry_in, op; outputs y and carry_out. Instantiated once; sequencer, counter and shift registers live in serial_alu_seq.

Verification
REQ-027 ADD 0xFF+0x01, WIDTH=8, start at cycle 0 -> done at cycle 9, result=0x00, cout=1, zero=1.
REQ-028 XOR 0xA5,0x5A -> result=0xFF, cout=0, zero=0; NAND 0xF0,0xCC -> result=0x3F.
REQ-029 start pulsed at cycles 0 and 4 with different operands -> only the first operation completes; the second is ignored; busy high cycles 1-8.
REQ-030 rst asserted at cycle 4 of an ADD -> next cycle busy=0, result=0, done never pulses; a fresh start then completes correctly.
REQ-031 With SERIAL_ALU_SEQ_SUB_EN: op=01, sub=1, 0x05-0x07 -> result=0xFE, cout=0; 0x07-0x05 -> result=0x02, cout=1.
REQ-032 Back-to-back ADD ops issued with start in the cycle after each done -> each done is spaced 10 cycles apart with correct results.
